// File: rtl/pe_inject_reg_pkg.sv
// Shared definitions for the PE injection regulator: address widths, packet field
// accessors common with the PE and switch, default sizing and the token update encoding.
`ifndef PE_INJECT_REG_PKG_SV
`define PE_INJECT_REG_PKG_SV

// Packet = {addr, data}, addr = {x, y} in the top bits.
`define PKT_ADDR(p, PW, AW)        p[(PW)-1 -: (AW)]
`define PKT_ADDRX(p, PW, XW)       p[(PW)-1 -: (XW)]
`define PKT_ADDRY(p, PW, XW, YW)   p[(PW)-(XW)-1 -: (YW)]
`define PKT_DATA(p, PW, AW)        p[(PW)-(AW)-1:0]

package pe_inject_reg_pkg;

    localparam int X_AW_DEF   = 2;
    localparam int Y_AW_DEF   = 2;
    localparam int A_W_DEF    = X_AW_DEF + Y_AW_DEF;
    localparam int P_W_DEF    = 16;
    localparam int DEPTH_DEF  = 4;
    localparam int PERIOD_DEF = 4;
    localparam int BURST_DEF  = 2;

    // {refill, consume} as seen by the token bucket in one cycle
    typedef enum logic [1:0] {
        TK_HOLD    = 2'b00,
        TK_CONSUME = 2'b01,
        TK_REFILL  = 2'b10,
        TK_BOTH    = 2'b11
    } tok_op_e;

    function automatic int addr_width(input int x_aw, input int y_aw);
        return x_aw + y_aw;
    endfunction

endpackage

`endif

// File: rtl/pe_inject_reg_inj_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty; head word is read
// combinationally from the memory at the read pointer.
import pe_inject_reg_pkg::*;

module inj_fifo #(
    parameter int P_W   = P_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [P_W-1:0]             i_data,
    input  logic                       i_pop,
    output logic [P_W-1:0]             o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [P_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointer update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/pe_inject_reg.sv
// Injection regulator: buffers PE packets and releases them to the HopliteRT
// switch PE port under a token-bucket rate limit (BURST tokens, one per PERIOD cycles).
import pe_inject_reg_pkg::*;

module pe_inject_reg #(
    parameter int P_W    = P_W_DEF,
    parameter int X_AW   = X_AW_DEF,
    parameter int Y_AW   = Y_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PERIOD = PERIOD_DEF,
    parameter int BURST  = BURST_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [P_W-1:0]               pe_pkt,
    input  logic                         pe_vld,
    output logic                         pe_rdy,
    output logic [P_W-1:0]               sw_pkt,
    output logic                         sw_vld,
    input  logic                         sw_ack,
    output logic [$clog2(BURST+1)-1:0]   tokens,
    output logic [15:0]                  inj_cnt
);

    localparam int A_W   = addr_width(X_AW, Y_AW);
    localparam int TK_W  = $clog2(BURST + 1);
    localparam int RC_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [TK_W-1:0] TK_MAX  = TK_W'(BURST);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(PERIOD - 1);

    logic [P_W-1:0]   w_head;
    logic [P_W-1:0]   w_head_fields;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_refill;
    tok_op_e          w_tk_op;
    logic [TK_W-1:0]  w_tokens_nxt;
    logic [TK_W-1:0]  r_tokens;
    logic [RC_W-1:0]  r_rc;
    logic [15:0]      r_inj_cnt;

    inj_fifo #(
        .P_W   (P_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (pe_pkt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Both handshake outputs depend on registered state only, never on sw_ack.
    assign pe_rdy   = ~w_full;
    assign sw_vld   = (w_count != {CNT_W{1'b0}}) & (r_tokens != {TK_W{1'b0}});
    assign w_push   = pe_vld & pe_rdy;
    assign w_pop    = sw_vld & sw_ack;
    assign w_refill = (r_rc == RC_LAST);
    assign w_tk_op  = tok_op_e'({w_refill, w_pop});
    assign tokens   = r_tokens;
    assign inj_cnt  = r_inj_cnt;

    // Forward the head through the shared field layout so the packet format lives in one place.
    assign w_head_fields = {`PKT_ADDRX(w_head, P_W, X_AW),
                            `PKT_ADDRY(w_head, P_W, X_AW, Y_AW),
                            `PKT_DATA(w_head, P_W, A_W)};

    // Head output, masked while the FIFO holds nothing.
    always_comb begin
        sw_pkt = {P_W{1'b0}};
        if (w_empty) begin
            sw_pkt = {P_W{1'b0}};
        end else begin
            sw_pkt = w_head_fields;
        end
    end

    // Token bucket next value; refill and consume together cancel, even at BURST.
    always_comb begin
        w_tokens_nxt = r_tokens;
        case (w_tk_op)
            TK_HOLD:    w_tokens_nxt = r_tokens;
            TK_CONSUME: w_tokens_nxt = r_tokens - {{(TK_W-1){1'b0}}, 1'b1};
            TK_REFILL: begin
                if (r_tokens == TK_MAX) begin
                    w_tokens_nxt = TK_MAX;
                end else begin
                    w_tokens_nxt = r_tokens + {{(TK_W-1){1'b0}}, 1'b1};
                end
            end
            TK_BOTH:    w_tokens_nxt = r_tokens;
            default:    w_tokens_nxt = r_tokens;
        endcase
    end

    // Free-running refill phase counter and token register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rc     <= {RC_W{1'b0}};
            r_tokens <= TK_MAX;
        end else begin
            r_tokens <= w_tokens_nxt;
            if (w_refill) begin
                r_rc <= {RC_W{1'b0}};
            end else begin
                r_rc <= r_rc + {{(RC_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Injected-packet counter, wraps modulo 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_cnt <= 16'h0000;
        end else if (w_pop) begin
            r_inj_cnt <= r_inj_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_pe_inject_reg.sv
// Directed bench: regulated instance (DEPTH=4, PERIOD=4, BURST=2) walked cycle by
// cycle, plus an unregulated instance (PERIOD=1) streaming packets.
module tb_pe_inject_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] pe_pkt = 16'h0000;
    logic        pe_vld = 1'b0;
    logic        pe_rdy;
    logic [15:0] sw_pkt;
    logic        sw_vld;
    logic        sw_ack = 1'b0;
    logic [1:0]  tokens;
    logic [15:0] inj_cnt;

    logic [15:0] pe_pkt1 = 16'h0000;
    logic        pe_vld1 = 1'b0;
    logic        pe_rdy1;
    logic [15:0] sw_pkt1;
    logic        sw_vld1;
    logic        sw_ack1 = 1'b0;
    logic [1:0]  tokens1;
    logic [15:0] inj_cnt1;

    int n_checks = 0;
    int n_errors = 0;
    int sent;
    int rcvd;

    always #5 clk = ~clk;

    pe_inject_reg #(.P_W(16), .X_AW(2), .Y_AW(2), .DEPTH(4), .PERIOD(4), .BURST(2)) dut (
        .clk(clk), .rst(rst), .pe_pkt(pe_pkt), .pe_vld(pe_vld), .pe_rdy(pe_rdy),
        .sw_pkt(sw_pkt), .sw_vld(sw_vld), .sw_ack(sw_ack), .tokens(tokens), .inj_cnt(inj_cnt)
    );

    pe_inject_reg #(.P_W(16), .X_AW(2), .Y_AW(2), .DEPTH(4), .PERIOD(1), .BURST(2)) dut_p1 (
        .clk(clk), .rst(rst), .pe_pkt(pe_pkt1), .pe_vld(pe_vld1), .pe_rdy(pe_rdy1),
        .sw_pkt(sw_pkt1), .sw_vld(sw_vld1), .sw_ack(sw_ack1), .tokens(tokens1), .inj_cnt(inj_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        // Reset state (refill edges fall on E4, E8, E12, ...)
        check("rst_pe_rdy", 32'(pe_rdy), 32'd1);
        check("rst_sw_vld", 32'(sw_vld), 32'd0);
        check("rst_sw_pkt", 32'(sw_pkt), 32'h0);
        check("rst_tokens", 32'(tokens), 32'd2);
        check("rst_inj_cnt", 32'(inj_cnt), 32'd0);
        step(); // E1
        check("idle_sw_vld", 32'(sw_vld), 32'd0);
        check("idle_tokens", 32'(tokens), 32'd2);

        // Fill with back-pressure
        pe_vld = 1'b1; pe_pkt = 16'h1000;
        step(); // E2
        check("lat_sw_vld", 32'(sw_vld), 32'd1);
        check("lat_sw_pkt", 32'(sw_pkt), 32'h1000);
        pe_pkt = 16'h1001; step(); // E3
        pe_pkt = 16'h1002; step(); // E4
        pe_pkt = 16'h1003; step(); // E5
        check("full_pe_rdy", 32'(pe_rdy), 32'd0);
        pe_pkt = 16'h1004; step(); // E6, refused
        check("full_pe_rdy2", 32'(pe_rdy), 32'd0);
        check("hold_sw_pkt", 32'(sw_pkt), 32'h1000);
        check("hold_tokens", 32'(tokens), 32'd2);
        pe_vld = 1'b0;
        step(); step(); // E7, E8
        check("hold_sw_pkt2", 32'(sw_pkt), 32'h1000);
        check("hold_inj_cnt", 32'(inj_cnt), 32'd0);

        // Release: burst of two, then one per PERIOD
        sw_ack = 1'b1;
        step(); // E9 pops 1000
        check("burst1_sw_pkt", 32'(sw_pkt), 32'h1001);
        check("burst1_tokens", 32'(tokens), 32'd1);
        check("burst1_inj", 32'(inj_cnt), 32'd1);
        check("burst1_pe_rdy", 32'(pe_rdy), 32'd1);
        step(); // E10 pops 1001
        check("burst2_tokens", 32'(tokens), 32'd0);
        check("starve_sw_vld", 32'(sw_vld), 32'd0);
        check("starve_sw_pkt", 32'(sw_pkt), 32'h1002);
        check("burst2_inj", 32'(inj_cnt), 32'd2);
        step(); // E11
        check("starve_sw_vld2", 32'(sw_vld), 32'd0);
        step(); // E12 refill
        check("refill_tokens", 32'(tokens), 32'd1);
        check("refill_sw_vld", 32'(sw_vld), 32'd1);
        step(); // E13 pops 1002
        check("rate_inj3", 32'(inj_cnt), 32'd3);
        check("rate_sw_vld", 32'(sw_vld), 32'd0);
        check("rate_sw_pkt", 32'(sw_pkt), 32'h1003);
        step(); step(); // E14, E15
        check("rate_sw_vld2", 32'(sw_vld), 32'd0);
        step(); // E16 refill
        check("rate_sw_vld3", 32'(sw_vld), 32'd1);
        step(); // E17 pops 1003
        check("drain_inj4", 32'(inj_cnt), 32'd4);
        check("drain_sw_vld", 32'(sw_vld), 32'd0);
        check("drain_sw_pkt", 32'(sw_pkt), 32'h0);
        check("drain_tokens", 32'(tokens), 32'd0);

        // Refill into an empty FIFO, then refill+pop at BURST
        sw_ack = 1'b0;
        step(); step(); step(); // E18..E20
        check("empty_refill_tokens", 32'(tokens), 32'd1);
        check("empty_refill_vld", 32'(sw_vld), 32'd0);
        step(); step(); step(); step(); // E21..E24
        check("sat_tokens", 32'(tokens), 32'd2);
        pe_vld = 1'b1; pe_pkt = 16'h2000;
        step(); // E25
        pe_vld = 1'b0;
        check("bp_sw_pkt", 32'(sw_pkt), 32'h2000);
        step(); // E26
        check("bp_sw_pkt2", 32'(sw_pkt), 32'h2000);
        check("bp_tokens", 32'(tokens), 32'd2);
        step(); // E27
        sw_ack = 1'b1;
        step(); // E28 refill and pop at BURST
        check("both_tokens", 32'(tokens), 32'd2);
        check("both_inj", 32'(inj_cnt), 32'd5);
        check("both_sw_vld", 32'(sw_vld), 32'd0);

        // Queue three packets with no tokens left, then reset
        pe_vld = 1'b1;
        pe_pkt = 16'h3000; step(); // E29
        pe_pkt = 16'h3001; step(); // E30 pops 3000
        pe_pkt = 16'h3002; step(); // E31 pops 3001
        pe_pkt = 16'h3003; step(); // E32 refill, no pop
        pe_pkt = 16'h3004; step(); // E33 pops 3002
        pe_pkt = 16'h3005; step(); // E34
        check("pre_rst_tokens", 32'(tokens), 32'd0);
        check("pre_rst_sw_vld", 32'(sw_vld), 32'd0);
        check("pre_rst_head", 32'(sw_pkt), 32'h3003);
        check("pre_rst_inj", 32'(inj_cnt), 32'd8);
        pe_vld = 1'b0; sw_ack = 1'b0; rst = 1'b1;
        step(); // E35
        rst = 1'b0;
        check("mid_rst_sw_vld", 32'(sw_vld), 32'd0);
        check("mid_rst_tokens", 32'(tokens), 32'd2);
        check("mid_rst_inj", 32'(inj_cnt), 32'd0);
        check("mid_rst_pe_rdy", 32'(pe_rdy), 32'd1);
        check("mid_rst_sw_pkt", 32'(sw_pkt), 32'h0);
        pe_vld = 1'b1; pe_pkt = 16'h4000;
        step();
        pe_vld = 1'b0;
        check("post_rst_sw_vld", 32'(sw_vld), 32'd1);
        check("post_rst_sw_pkt", 32'(sw_pkt), 32'h4000);

        // Unregulated instance: one packet per cycle
        sent = 0;
        rcvd = 0;
        pe_vld1 = 1'b1;
        sw_ack1 = 1'b1;
        for (int c = 0; c < 24; c++) begin
            pe_pkt1 = 16'h5000 + 16'(sent);
            if (sw_vld1) begin
                check("p1_order", 32'(sw_pkt1), 32'h5000 + 32'(rcvd));
                rcvd++;
            end
            check("p1_tokens_min", 32'(tokens1 >= 2'd1), 32'd1);
            check("p1_pe_rdy", 32'(pe_rdy1), 32'd1);
            if (pe_rdy1) sent++;
            step();
        end
        pe_vld1 = 1'b0;
        check("p1_rcvd_stream", 32'(rcvd), 32'd23);
        if (sw_vld1) begin
            check("p1_order_last", 32'(sw_pkt1), 32'h5000 + 32'(rcvd));
            rcvd++;
        end
        step();
        check("p1_rcvd_total", 32'(rcvd), 32'd24);
        check("p1_inj_cnt", 32'(inj_cnt1), 32'd24);
        check("p1_empty", 32'(sw_vld1), 32'd0);
        sw_ack1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_inject_reg.md
# pe_inject_reg

Injection regulator between a processing element (PE) and its HopliteRT switch port. It buffers packets offered by the PE in a small synchronous FIFO and releases them to the switch under a token-bucket rate limit, which bounds each client's injection rate as real-time analysis requires. The PE sees a simple valid/ready interface. The switch sees a valid/accept interface at the PE input port.

## Interface
Parameters:
- P_W, 16, packet width; packet = {addr, data}, addr = {x, y} in the top A_W = X_AW+Y_AW bits
- X_AW, 2, torus X address width
- Y_AW, 2, torus Y address width
- DEPTH, 4, FIFO depth in packets; power of two, ≥2
- PERIOD, 4, cycles per token refill; ≥1 (1 = unregulated)
- BURST, 2, token bucket capacity; ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pe_pkt  in  P_W  packet offered by the PE
- pe_vld  in  1  pe_pkt valid
- pe_rdy  out  1  block accepts pe_pkt this cycle; PE advances on pe_vld & pe_rdy
- sw_pkt  out  P_W  packet offered to the switch PE port
- sw_vld  out  1  sw_pkt valid
- sw_ack  in  1  switch took sw_pkt this cycle; ignored when sw_vld = 0
- tokens  out  $clog2(BURST+1)  current token count, for debug and bench visibility
- inj_cnt  out  16  packets injected since reset; wraps modulo 2^16

## Operation
- Push: pe_vld & pe_rdy writes pe_pkt at the write pointer.
- pe_rdy = !full. It is a function of registered occupancy only, so no combinational path exists from sw_ack to pe_rdy.
- sw_vld = !empty & (tokens != 0). sw_pkt = FIFO head. sw_pkt is held stable while sw_vld = 1 and sw_ack = 0.
- Pop: sw_vld & sw_ack advances the read pointer, decrements tokens and increments inj_cnt.
- Refill counter rc counts 0..PERIOD-1 every cycle and wraps. On rc == PERIOD-1, tokens increments, saturating at BURST.
- Same-cycle refill and consume: net tokens unchanged. This includes tokens == BURST, which stays at BURST.
- Same-cycle push and pop: occupancy unchanged. When full, no push occurs even if a pop happens that cycle.
- Pointers are $clog2(DEPTH)+1 bits. Full/empty come from the MSB-differing / equal comparison.
- Packets are forwarded unmodified in FIFO order. No drop and no reordering.

## Timing
- Reset values: pe_rdy = 1, sw_vld = 0, sw_pkt = 0 (the memory is don't-care but the output is masked to 0 while empty), tokens = BURST, inj_cnt = 0, rc = 0, FIFO empty.
- Reset mid-operation flushes the FIFO. In-flight contents are lost and the bench must not expect them.
- Latency into an empty FIFO with tokens available: push at edge N gives sw_vld = 1 in cycle N+1.
- Sustained throughput:
  - PERIOD = 1: one packet per cycle.
  - Otherwise: after the initial burst of BURST packets, one packet per PERIOD cycles.
- Token starvation: sw_vld drops to 0 while the FIFO is non-empty. It reasserts in the cycle after the refill edge.
- Switch back-pressure (sw_ack = 0) consumes no token and does not pop.

## Structure
- Shared include/package holds:
  - the A_W definition;
  - the packet field macros (addr, addrx, addry, data), common with the PE and switch;
  - the default DEPTH/PERIOD/BURST constants.
- Sub-module inj_fifo: a synchronous FIFO (DEPTH×P_W, push/pop, full/empty, count). The regulator and counters live in pe_inject_reg.

## Test plan
1. Reset, then idle, with DEPTH=4, PERIOD=4, BURST=2 -> pe_rdy=1, sw_vld=0, tokens=2, inj_cnt=0.
2. Push 4 packets 0x1000..0x1003 with sw_ack held 0 -> pe_rdy=0 after the 4th push, 5th offer not accepted, sw_pkt=0x1000 stable, tokens=2.
3. With the FIFO full, raise sw_ack=1 -> 0x1000 and 0x1001 leave on consecutive cycles, tokens reaches 0, and thereafter one packet per 4 cycles (0x1002, 0x1003); inj_cnt=4; order preserved.
4. PERIOD=1, PE streaming every cycle, sw_ack=1 -> one packet per cycle, tokens never drops below BURST-1, occupancy steady, no loss over 20 packets.
5. Tokens at BURST with refill and pop in the same cycle -> tokens stays 2. Tokens at 0 with refill and no pop -> tokens 1 and sw_vld=1 next cycle.
6. Assert rst with 3 packets queued and tokens=0 -> next cycle empty, sw_vld=0, tokens=2, inj_cnt=0. The next push appears on sw_pkt one cycle later.
